// File: rtl/i2s_capture_pkg.sv
// Shared I2S constants and the capture frame-sync state encoding.
// Imported by the capture block, its FIFO and the neighbouring I2S blocks.
package i2s_capture_pkg;

  // Legal bit-clocks-per-stereo-frame settings.
  localparam int unsigned CLOCKS_32 = 32;
  localparam int unsigned CLOCKS_64 = 64;

  // Widths of the status outputs.
  localparam int unsigned LevelW = 5;
  localparam int unsigned DropW  = 8;

  // Frame-sync state machine encoding.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSync = 2'd1,
    StRun  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/i2s_capture_if.sv
// I2S capture data interface: bit strobe, frame position and channel words
// from the receiver side, plus the stereo-pair valid/ready output handshake.
//   slave  : the capture block (consumes i2s_rx words, produces pairs)
//   master : the environment (drives i2s_rx side and the consumer ready)
interface i2s_capture_if #(
  parameter int unsigned BITS = 24
) ();

  logic            sample;      // one-ck bit strobe
  logic [5:0]      frame_posn;  // frame bit counter
  logic [BITS-1:0] left;        // left word from i2s_rx
  logic [BITS-1:0] right;       // right word from i2s_rx
  logic            out_valid;   // head pair available
  logic            out_ready;   // consumer accepts head pair
  logic [BITS-1:0] out_left;    // head-of-FIFO left word
  logic [BITS-1:0] out_right;   // head-of-FIFO right word

  modport slave (
    input  sample, frame_posn, left, right, out_ready,
    output out_valid, out_left, out_right
  );

  modport master (
    output sample, frame_posn, left, right, out_ready,
    input  out_valid, out_left, out_right
  );

endinterface

// File: rtl/i2s_capture_sync_fifo.sv
// Synchronous FIFO holding captured stereo pairs, with a registered head word.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/wdata_i: write request and data (ignored when full unless popping)
//   pop_i         : read request (ignored when empty)
//   flush_i       : empty the FIFO; a same-cycle push is discarded
//   rdata_o       : head entry; holds the last popped value when empty
//   level_o       : occupancy 0..DEPTH; full_o / empty_o derived from it
module i2s_capture_sync_fifo
  import i2s_capture_pkg::*;
#(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [WIDTH-1:0]  rdata_o,
  output logic [LevelW-1:0] level_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              pop_ok, push_ok;

  assign full_o  = (level_q == LevelW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    rdata_d  = rdata_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      level_d = level_q + LevelW'(push_ok) - LevelW'(pop_ok);
      // Preload the next head; bypass when the incoming word becomes the head.
      if (level_d != '0) begin
        rdata_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? wdata_i : mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign level_o = level_q;

endmodule

// File: rtl/i2s_capture.sv
// I2S stereo-pair capture: waits for a frame wrap after enable, then captures
// {left,right} once per frame at CAPTURE_POSN into a FIFO, with overflow status.
//   ck, rst_n   : system clock, asynchronous active-low reset
//   bus         : i2s_capture_if slave (sample/frame_posn/left/right in,
//                 out_valid/out_ready/out_left/out_right handshake)
//   enable      : capture enable level; low returns to idle, FIFO retained
//   flush       : one-ck pulse emptying the FIFO
//   clr_ovf     : one-ck pulse clearing overflow and drop_count
//   level       : FIFO occupancy
//   overflow    : sticky, a pair was dropped
//   drop_count  : saturating count of dropped pairs
module i2s_capture
  import i2s_capture_pkg::*;
#(
  parameter int unsigned BITS         = 24,
  parameter int unsigned CLOCKS       = 64,  // 32 or 64
  parameter int unsigned DEPTH        = 4,   // power of two, 2..16
  parameter int unsigned CAPTURE_POSN = 1
) (
  input  logic              ck,
  input  logic              rst_n,
  i2s_capture_if.slave      bus,
  input  logic              enable,
  input  logic              flush,
  input  logic              clr_ovf,
  output logic [LevelW-1:0] level,
  output logic              overflow,
  output logic [DropW-1:0]  drop_count
);

  cap_state_e       state_q;
  logic [5:0]       pos;
  logic             cap, pop, drop;
  logic             fifo_full, fifo_empty;
  logic [2*BITS-1:0] fifo_rdata;
  logic             overflow_q, overflow_d;
  logic [DropW-1:0] drop_count_q, drop_count_d;

  // A 32-clock frame only uses the low five counter bits.
  assign pos = (CLOCKS == CLOCKS_32) ? {1'b0, bus.frame_posn[4:0]} : bus.frame_posn;
  assign cap = bus.sample && (pos == 6'(CAPTURE_POSN)) && (state_q == StRun);

  // SYNC waits for a frame wrap so the partial frame after enable is skipped.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else if (!enable) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle:  state_q <= StSync;
        StSync:  if (bus.sample && (pos == '0)) state_q <= StRun;
        StRun:   state_q <= StRun;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pop  = bus.out_valid && bus.out_ready;
  // Flush discards a coincident capture without counting it as a drop.
  assign drop = cap && !flush && fifo_full && !pop;

  i2s_capture_sync_fifo #(
    .WIDTH(2 * BITS),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (ck),
    .rst_ni (rst_n),
    .push_i (cap),
    .wdata_i({bus.left, bus.right}),
    .pop_i  (pop),
    .flush_i(flush),
    .rdata_o(fifo_rdata),
    .level_o(level),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_left  = fifo_rdata[2*BITS-1:BITS];
  assign bus.out_right = fifo_rdata[BITS-1:0];

  // A drop in the same cycle as clr_ovf wins and restarts the count at one.
  always_comb begin
    overflow_d   = clr_ovf ? 1'b0 : overflow_q;
    drop_count_d = clr_ovf ? '0 : drop_count_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_d != {DropW{1'b1}}) drop_count_d = drop_count_d + DropW'(1);
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_i2s_capture.sv
// Directed bench for i2s_capture: 64-clock/24-bit instance plus a
// 32-clock/16-bit instance, 16 ck per bit from a shared frame counter.
module tb_i2s_capture;

  logic       ck;
  logic       rst_n, enable, flush, clr_ovf;
  logic [4:0] level;
  logic       overflow;
  logic [7:0] drop_count;
  logic       enable2;
  logic [4:0] level2;
  logic       overflow2;
  logic [7:0] drop_count2;

  int n_checks, n_pass, n_fail;

  logic [23:0] pl [0:4];
  logic [23:0] pr [0:4];
  logic [23:0] el [0:3];
  logic [23:0] er [0:3];

  i2s_capture_if #(.BITS(24)) bus ();
  i2s_capture_if #(.BITS(16)) bus2 ();

  i2s_capture #(.BITS(24), .CLOCKS(64), .DEPTH(4), .CAPTURE_POSN(1)) u_dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .bus       (bus),
    .enable    (enable),
    .flush     (flush),
    .clr_ovf   (clr_ovf),
    .level     (level),
    .overflow  (overflow),
    .drop_count(drop_count)
  );

  i2s_capture #(.BITS(16), .CLOCKS(32), .DEPTH(4), .CAPTURE_POSN(1)) u_dut32 (
    .ck        (ck),
    .rst_n     (rst_n),
    .bus       (bus2),
    .enable    (enable2),
    .flush     (1'b0),
    .clr_ovf   (1'b0),
    .level     (level2),
    .overflow  (overflow2),
    .drop_count(drop_count2)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  // Bit strobe every 16 ck; frame position advances after each strobe.
  initial begin
    int div;
    int p;
    div = 0;
    p   = 0;
    bus.sample = 1'b0;  bus.frame_posn = '0;
    bus2.sample = 1'b0; bus2.frame_posn = '0;
    forever begin
      @(posedge ck);
      #1;
      if (div == 15) begin
        div = 0;
        p   = (p + 1) % 64;
      end else begin
        div = div + 1;
      end
      bus.sample      = (div == 15);
      bus.frame_posn  = 6'(p);
      bus2.sample     = (div == 15);
      bus2.frame_posn = 6'(p);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Return at the negedge where frame_posn==p and sample==s (bounded).
  task automatic wait_bit(input int p, input logic s);
    int n;
    n = 0;
    @(negedge ck);
    while (!((bus.frame_posn == 6'(p)) && (bus.sample == s)) && (n < 3000)) begin
      @(negedge ck);
      n++;
    end
    if (n >= 3000) begin
      n_checks++;
      n_fail++;
      $error("FAIL wait_bit_timeout observed=%0d expected=%0d", bus.frame_posn, p);
    end
  endtask

  // Present a pair at the frame wrap; return just before the capture edge.
  task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
    wait_bit(0, 1'b1);
    bus.left  = l;
    bus.right = r;
    wait_bit(1, 1'b1);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0;
    pl = '{24'h123456, 24'h000000, 24'h555555, 24'habcdef, 24'h987654};
    pr = '{24'hffffff, 24'haaaaaa, 24'h123456, 24'h012345, 24'hfedcba};
    el = '{24'h000000, 24'h555555, 24'habcdef, 24'h2468ac};
    er = '{24'haaaaaa, 24'h123456, 24'h012345, 24'h13579b};
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
    bus.out_ready = 1'b0; bus.left = '0; bus.right = '0;
    enable2 = 1'b0; bus2.out_ready = 1'b0; bus2.left = '0; bus2.right = '0;

    // Reset state
    repeat (3) @(negedge ck);
    chk("rst_valid", bus.out_valid, 32'd0);
    chk("rst_level", level, 32'd0);
    chk("rst_ovf", overflow, 32'd0);
    chk("rst_drop", drop_count, 32'd0);
    chk("rst_left", bus.out_left, 32'd0);
    chk("rst_right", bus.out_right, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge ck);

    // Enable mid-frame: capture point of the partial frame is skipped
    wait_bit(1, 1'b0);
    enable = 1'b1;
    bus.left = 24'h111111; bus.right = 24'h222222;
    wait_bit(1, 1'b1);
    @(negedge ck);
    chk("partial_no_cap", level, 32'd0);
    chk("partial_no_valid", bus.out_valid, 32'd0);
    send_pair(24'hf0f0f0, 24'hcafedb);
    chk("first_precap_level", level, 32'd0);
    @(negedge ck);
    chk("first_valid", bus.out_valid, 32'd1);
    chk("first_level", level, 32'd1);
    chk("first_left", bus.out_left, 32'hf0f0f0);
    chk("first_right", bus.out_right, 32'hcafedb);
    bus.out_ready = 1'b1;
    @(negedge ck);
    bus.out_ready = 1'b0;
    chk("pop_valid", bus.out_valid, 32'd0);
    chk("pop_level", level, 32'd0);
    chk("pop_hold_left", bus.out_left, 32'hf0f0f0);

    // Back-pressure: fill to DEPTH, fifth pair dropped
    for (int i = 0; i < 5; i++) begin
      send_pair(pl[i], pr[i]);
      @(negedge ck);
      chk("fill_level", level, (i < 4) ? 32'(i + 1) : 32'd4);
      if (i == 3) chk("fill_no_ovf", overflow, 32'd0);
    end
    chk("full_head_left", bus.out_left, 32'h123456);
    chk("full_head_right", bus.out_right, 32'hffffff);
    chk("ovf_set", overflow, 32'd1);
    chk("drop_one", drop_count, 32'd1);

    // Full FIFO with pop at the capture edge: push accepted
    send_pair(24'h2468ac, 24'h13579b);
    bus.out_ready = 1'b1;
    @(negedge ck);
    bus.out_ready = 1'b0;
    chk("fullpp_level", level, 32'd4);
    chk("fullpp_drop", drop_count, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("drain_left", bus.out_left, 32'(el[k]));
      chk("drain_right", bus.out_right, 32'(er[k]));
      bus.out_ready = 1'b1;
      @(negedge ck);
    end
    bus.out_ready = 1'b0;
    chk("drain_level", level, 32'd0);
    chk("drain_valid", bus.out_valid, 32'd0);
    chk("drain_hold_left", bus.out_left, 32'h2468ac);

    // Flush coincident with a capture
    send_pair(24'h0f1e2d, 24'h3c4b5a);
    @(negedge ck);
    chk("preflush_level", level, 32'd1);
    send_pair(24'h778899, 24'h665544);
    flush = 1'b1;
    @(negedge ck);
    flush = 1'b0;
    chk("flush_level", level, 32'd0);
    chk("flush_valid", bus.out_valid, 32'd0);
    chk("flush_drop", drop_count, 32'd1);
    chk("flush_ovf", overflow, 32'd1);

    // Asynchronous reset while a pair waits, then resync on a fresh wrap
    send_pair(24'h13579b, 24'h2468ac);
    @(negedge ck);
    chk("prerst_valid", bus.out_valid, 32'd1);
    bus.left = 24'h5a5a5a; bus.right = 24'ha5a5a5;
    wait_bit(1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 32'd0);
    chk("arst_left", bus.out_left, 32'd0);
    chk("arst_right", bus.out_right, 32'd0);
    chk("arst_level", level, 32'd0);
    chk("arst_ovf", overflow, 32'd0);
    chk("arst_drop", drop_count, 32'd0);
    @(negedge ck);
    rst_n = 1'b1;
    wait_bit(1, 1'b1);
    @(negedge ck);
    chk("rst_no_cap", level, 32'd0);
    send_pair(24'ha1b2c3, 24'hd4e5f6);
    @(negedge ck);
    chk("resync_level", level, 32'd1);
    chk("resync_left", bus.out_left, 32'ha1b2c3);

    // Disable: no capture, contents retained and readable
    enable = 1'b0;
    bus.left = 24'h000001; bus.right = 24'h000002;
    wait_bit(1, 1'b1);
    @(negedge ck);
    chk("dis_level", level, 32'd1);
    chk("dis_valid", bus.out_valid, 32'd1);
    chk("dis_left", bus.out_left, 32'ha1b2c3);
    chk("dis_right", bus.out_right, 32'hd4e5f6);
    bus.out_ready = 1'b1;
    @(negedge ck);
    bus.out_ready = 1'b0;
    chk("dis_pop_level", level, 32'd0);

    // Overflow again, then clr_ovf coincident with a drop
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_pair(24'(32'h100000 + i), 24'(32'h200000 + i));
      if (i == 5) clr_ovf = 1'b1;
      @(negedge ck);
      clr_ovf = 1'b0;
      if (i == 4) chk("ovf2_drop", drop_count, 32'd1);
    end
    chk("clrdrop_ovf", overflow, 32'd1);
    chk("clrdrop_count", drop_count, 32'd1);
    chk("clrdrop_level", level, 32'd4);
    clr_ovf = 1'b1;
    @(negedge ck);
    clr_ovf = 1'b0;
    chk("clr_ovf", overflow, 32'd0);
    chk("clr_drop", drop_count, 32'd0);
    enable = 1'b0;
    flush = 1'b1;
    @(negedge ck);
    flush = 1'b0;
    chk("flush2_level", level, 32'd0);
    chk("flush2_valid", bus.out_valid, 32'd0);

    // 32-clock frame, 16-bit words: one pair per 32 bit clocks
    bus2.left = 16'hface; bus2.right = 16'h1234;
    wait_bit(30, 1'b0);
    enable2 = 1'b1;
    wait_bit(33, 1'b1);
    chk("c32_precap_level", level2, 32'd0);
    @(negedge ck);
    chk("c32_valid", bus2.out_valid, 32'd1);
    chk("c32_left", bus2.out_left, 32'hface);
    chk("c32_right", bus2.out_right, 32'h1234);
    chk("c32_level", level2, 32'd1);
    bus2.left = 16'h0bad; bus2.right = 16'hc0de;
    wait_bit(1, 1'b1);
    @(negedge ck);
    chk("c32_level2", level2, 32'd2);
    chk("c32_head_hold", bus2.out_left, 32'hface);
    bus2.out_ready = 1'b1;
    @(negedge ck);
    bus2.out_ready = 1'b0;
    chk("c32_pop_left", bus2.out_left, 32'h0bad);
    chk("c32_pop_right", bus2.out_right, 32'hc0de);
    chk("c32_pop_level", level2, 32'd1);
    chk("c32_no_ovf", overflow2, 32'd0);
    chk("c32_no_drop", drop_count2, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
